// File: rtl/olivia_pipe_hazard_ctrl.sv
// olivia_pipe_hazard_ctrl: EX/MEM/WB destination tracking, forwarding selects, load-use stall and branch flush
module olivia_pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter bit ENABLE_FWD = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_rn,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

    logic                  r_ex_valid, r_ex_rw, r_ex_mr, r_ex_use_rn, r_ex_use_src2;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_ex_rn, r_ex_src2;
    logic                  r_mem_valid, r_mem_rw, r_mem_mr;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_valid, r_wb_rw;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

    // A live producer writing a real (non-XZR) register that this source actually reads
    function automatic logic hit(input logic v, input logic rw, input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] s, input logic use_s);
        return v & rw & use_s & (rd == s) & (s != ZR);
    endfunction

    logic w_ida_ex, w_idb_ex, w_ida_mem, w_idb_mem, w_ida_wb, w_idb_wb;
    logic w_exa_mem, w_exb_mem, w_exa_wb, w_exb_wb;
    logic w_raw, w_flush, w_stall, w_load;

    assign w_ida_ex  = hit(r_ex_valid, r_ex_rw, r_ex_rd, id_rn, id_use_rn);
    assign w_idb_ex  = hit(r_ex_valid, r_ex_rw, r_ex_rd, id_src2, id_use_src2);
    assign w_ida_mem = hit(r_mem_valid, r_mem_rw, r_mem_rd, id_rn, id_use_rn);
    assign w_idb_mem = hit(r_mem_valid, r_mem_rw, r_mem_rd, id_src2, id_use_src2);
    assign w_ida_wb  = hit(r_wb_valid, r_wb_rw, r_wb_rd, id_rn, id_use_rn);
    assign w_idb_wb  = hit(r_wb_valid, r_wb_rw, r_wb_rd, id_src2, id_use_src2);

    // A MEM load has no data yet, so it can only ever be forwarded once it reaches WB
    assign w_exa_mem = hit(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_rn, r_ex_use_rn) & ~r_mem_mr;
    assign w_exb_mem = hit(r_mem_valid, r_mem_rw, r_mem_rd, r_ex_src2, r_ex_use_src2) & ~r_mem_mr;
    assign w_exa_wb  = hit(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_rn, r_ex_use_rn);
    assign w_exb_wb  = hit(r_wb_valid, r_wb_rw, r_wb_rd, r_ex_src2, r_ex_use_src2);

    assign w_raw   = ENABLE_FWD ? (r_ex_mr & (w_ida_ex | w_idb_ex))
                                : (w_ida_ex | w_idb_ex | w_ida_mem | w_idb_mem | w_ida_wb | w_idb_wb);
    assign w_flush = ex_branch_taken & r_ex_valid;
    assign w_stall = id_valid & w_raw & ~w_flush;
    assign w_load  = ~(w_stall | w_flush);

    assign stall_if_id  = w_stall;
    assign flush_if_id  = w_flush;
    assign fwd_a        = !ENABLE_FWD ? 2'b00 : w_exa_mem ? 2'b01 : w_exa_wb ? 2'b10 : 2'b00;
    assign fwd_b        = !ENABLE_FWD ? 2'b00 : w_exb_mem ? 2'b01 : w_exb_wb ? 2'b10 : 2'b00;
    assign ex_valid     = r_ex_valid;
    assign mem_valid    = r_mem_valid;
    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_valid & r_wb_rw;
    assign wb_rd        = r_wb_rd;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    // EX captures the ID instruction, or a fully cleared bubble on stall/flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rw       <= 1'b0;
            r_ex_mr       <= 1'b0;
            r_ex_use_rn   <= 1'b0;
            r_ex_use_src2 <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_rn       <= '0;
            r_ex_src2     <= '0;
        end else begin
            r_ex_valid    <= w_load & id_valid;
            r_ex_rw       <= w_load & id_reg_write;
            r_ex_mr       <= w_load & id_mem_read;
            r_ex_use_rn   <= w_load & id_use_rn;
            r_ex_use_src2 <= w_load & id_use_src2;
            r_ex_rd       <= w_load ? id_rd : '0;
            r_ex_rn       <= w_load ? id_rn : '0;
            r_ex_src2     <= w_load ? id_src2 : '0;
        end
    end

    // MEM and WB always advance; nothing past ID is ever held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_mr    <= 1'b0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_rd     <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_rw    <= r_ex_rw;
            r_mem_mr    <= r_ex_mr;
            r_mem_rd    <= r_ex_rd;
            r_wb_valid  <= r_mem_valid;
            r_wb_rw     <= r_mem_rw;
            r_wb_rd     <= r_mem_rd;
        end
    end

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_olivia_pipe_hazard_ctrl.sv
// tb_olivia_pipe_hazard_ctrl: vector table plus hand sequences for stall, flush, forwarding, reset and saturation
module tb_olivia_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rn, s2;
        logic       urn, us2;
        logic [4:0] rd;
        logic       rw, mr, br;
    } in_t;

    typedef struct packed {
        logic        st, fl;
        logic [1:0]  fa, fb;
        logic        exv, memv, wbv, wbw;
        logic [4:0]  wbrd;
        logic [15:0] sc, fc;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    in_t im, in_nf, isat;
    out_t m_act;
    int checks = 0, failures = 0;
    out_t exp_q[$];
    vec_t tbl[20];

    logic        m_st, m_fl, m_exv, m_memv, m_wbv, m_wbw;
    logic [1:0]  m_fa, m_fb;
    logic [4:0]  m_wbrd;
    logic [15:0] m_sc, m_fc;
    logic        n_st, n_fl, n_exv, n_memv, n_wbv, n_wbw;
    logic [1:0]  n_fa, n_fb;
    logic [4:0]  n_wbrd;
    logic [15:0] n_sc, n_fc;
    logic        s_st, s_fl, s_exv, s_memv, s_wbv, s_wbw;
    logic [1:0]  s_fa, s_fb;
    logic [4:0]  s_wbrd;
    logic [1:0]  s_sc, s_fc;

    olivia_pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(im.v), .id_rn(im.rn), .id_src2(im.s2),
        .id_use_rn(im.urn), .id_use_src2(im.us2), .id_rd(im.rd), .id_reg_write(im.rw),
        .id_mem_read(im.mr), .ex_branch_taken(im.br), .stall_if_id(m_st), .flush_if_id(m_fl),
        .fwd_a(m_fa), .fwd_b(m_fb), .ex_valid(m_exv), .mem_valid(m_memv), .wb_valid(m_wbv),
        .wb_reg_write(m_wbw), .wb_rd(m_wbrd), .stall_cnt(m_sc), .flush_cnt(m_fc)
    );

    olivia_pipe_hazard_ctrl #(.ENABLE_FWD(1'b0)) u_nf (
        .clk(clk), .rst(rst), .id_valid(in_nf.v), .id_rn(in_nf.rn), .id_src2(in_nf.s2),
        .id_use_rn(in_nf.urn), .id_use_src2(in_nf.us2), .id_rd(in_nf.rd), .id_reg_write(in_nf.rw),
        .id_mem_read(in_nf.mr), .ex_branch_taken(in_nf.br), .stall_if_id(n_st), .flush_if_id(n_fl),
        .fwd_a(n_fa), .fwd_b(n_fb), .ex_valid(n_exv), .mem_valid(n_memv), .wb_valid(n_wbv),
        .wb_reg_write(n_wbw), .wb_rd(n_wbrd), .stall_cnt(n_sc), .flush_cnt(n_fc)
    );

    olivia_pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(isat.v), .id_rn(isat.rn), .id_src2(isat.s2),
        .id_use_rn(isat.urn), .id_use_src2(isat.us2), .id_rd(isat.rd), .id_reg_write(isat.rw),
        .id_mem_read(isat.mr), .ex_branch_taken(isat.br), .stall_if_id(s_st), .flush_if_id(s_fl),
        .fwd_a(s_fa), .fwd_b(s_fb), .ex_valid(s_exv), .mem_valid(s_memv), .wb_valid(s_wbv),
        .wb_reg_write(s_wbw), .wb_rd(s_wbrd), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    always_comb m_act = {m_st, m_fl, m_fa, m_fb, m_exv, m_memv, m_wbv, m_wbw, m_wbrd, m_sc, m_fc};

    function automatic in_t ins(input int rn, s2, urn, us2, rd, rw, mr);
        return in_t'({1'b1, 5'(rn), 5'(s2), 1'(urn), 1'(us2), 5'(rd), 1'(rw), 1'(mr), 1'b0});
    endfunction

    function automatic out_t ex(input int st, fl, fa, fb, exv, memv, wbv, wbw, wbrd, sc, fc);
        return out_t'({1'(st), 1'(fl), 2'(fa), 2'(fb), 1'(exv), 1'(memv), 1'(wbv), 1'(wbw),
                       5'(wbrd), 16'(sc), 16'(fc)});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, expv);
        end
    endtask

    in_t idle, ld2, add5, w3a, sub_i, w3b, ind, r3a, w3c, w3d, r3b, ld31, a31, r31, addb, idleb;
    in_t add4, r4, ldx;
    out_t e;

    initial begin
        idle = '0;
        ld2 = ins(1, 0, 1, 0, 2, 1, 1);
        add5 = ins(2, 6, 1, 1, 5, 1, 0);
        w3a = ins(7, 8, 1, 1, 3, 1, 0);
        sub_i = ins(3, 3, 1, 1, 9, 1, 0);
        w3b = ins(14, 15, 1, 1, 3, 1, 0);
        ind = ins(11, 12, 1, 1, 10, 1, 0);
        r3a = ins(3, 3, 1, 1, 13, 1, 0);
        w3c = ins(16, 17, 1, 1, 3, 1, 0);
        w3d = ins(18, 19, 1, 1, 3, 1, 0);
        r3b = ins(3, 3, 1, 1, 20, 1, 0);
        ld31 = ins(1, 0, 0, 0, 31, 1, 1);
        a31 = ins(31, 31, 1, 1, 31, 1, 0);
        r31 = ins(31, 31, 1, 1, 4, 1, 0);
        addb = add5; addb.br = 1'b1;
        idleb = idle; idleb.br = 1'b1;
        add4 = ins(0, 0, 0, 0, 4, 1, 0);
        r4 = ins(4, 4, 1, 1, 6, 1, 0);
        ldx = ins(2, 0, 1, 0, 2, 1, 1);

        tbl[0]  = '{idle,  ex(0,0,0,0, 0,0,0,0,  0, 0,0)};
        tbl[1]  = '{ld2,   ex(0,0,0,0, 0,0,0,0,  0, 0,0)};
        tbl[2]  = '{add5,  ex(1,0,0,0, 1,0,0,0,  0, 0,0)};
        tbl[3]  = '{add5,  ex(0,0,0,0, 0,1,0,0,  0, 1,0)};
        tbl[4]  = '{w3a,   ex(0,0,2,0, 1,0,1,1,  2, 1,0)};
        tbl[5]  = '{sub_i, ex(0,0,0,0, 1,1,0,0,  0, 1,0)};
        tbl[6]  = '{w3b,   ex(0,0,1,1, 1,1,1,1,  5, 1,0)};
        tbl[7]  = '{ind,   ex(0,0,0,0, 1,1,1,1,  3, 1,0)};
        tbl[8]  = '{r3a,   ex(0,0,0,0, 1,1,1,1,  9, 1,0)};
        tbl[9]  = '{w3c,   ex(0,0,2,2, 1,1,1,1,  3, 1,0)};
        tbl[10] = '{w3d,   ex(0,0,0,0, 1,1,1,1, 10, 1,0)};
        tbl[11] = '{r3b,   ex(0,0,0,0, 1,1,1,1, 13, 1,0)};
        tbl[12] = '{ld31,  ex(0,0,1,1, 1,1,1,1,  3, 1,0)};
        tbl[13] = '{a31,   ex(0,0,0,0, 1,1,1,1,  3, 1,0)};
        tbl[14] = '{r31,   ex(0,0,0,0, 1,1,1,1, 20, 1,0)};
        tbl[15] = '{idle,  ex(0,0,0,0, 1,1,1,1, 31, 1,0)};
        tbl[16] = '{ld2,   ex(0,0,0,0, 0,1,1,1, 31, 1,0)};
        tbl[17] = '{addb,  ex(0,1,0,0, 1,0,1,1,  4, 1,0)};
        tbl[18] = '{idleb, ex(0,0,0,0, 0,1,0,0,  0, 1,1)};
        tbl[19] = '{idle,  ex(0,0,0,0, 0,0,1,1,  2, 1,1)};

        im = '0; in_nf = '0; isat = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset", 64'(m_act), 64'(0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 20; k++) begin
            im = tbl[k].i;
            exp_q.push_back(tbl[k].o);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d", k), 64'(m_act), 64'(e));
            @(posedge clk); #1;
        end
        im = '0;

        in_nf = add4;
        @(posedge clk); #1;
        in_nf = r4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("nf_stall%0d", k), 64'({n_st, n_fa, n_fb}), 64'(5'b10000));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("nf_release", 64'(n_st), 64'(0));
        chk("nf_cnt", 64'(n_sc), 64'(3));
        @(posedge clk); #1;
        in_nf = '0;

        isat = ldx;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk($sformatf("sat_stall%0d", k), 64'(s_st), 64'(k % 2 == 1));
            @(posedge clk); #1;
        end
        isat = '0;
        @(negedge clk);
        chk("sat_cnt", 64'(s_sc), 64'(3));
        @(posedge clk); #1;

        im = ld2;
        @(posedge clk); #1;
        im = add5;
        #2 chk("pre_rst_stall", 64'(m_st), 64'(1));
        rst = 1'b0;
        #1 chk("rst_async", 64'(m_act), 64'(0));
        @(negedge clk) rst = 1'b1;
        im = ind;
        #1 chk("post_rst_idle", 64'({m_st, m_exv}), 64'(0));
        @(posedge clk); #1;
        chk("post_rst_flow", 64'({m_st, m_exv, m_sc}), 64'({1'b0, 1'b1, 16'd0}));
        im = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
